// File: rtl/display_uart_tx.sv
// display_uart_tx: display-side device behind the LC-3 DDR/DSR registers.
// A DDR load hands a character to this block, which sends it as an 8N1 UART
// frame on tx. It drives DSR[15] through the external-load path: ready is
// cleared when a character is accepted and set again after the stop bit.
module display_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        ld_ddr,
    input  logic [15:0] mdr_out,
    output logic        ld_dsr_ext,
    output logic [15:0] dsr_ext_out,
    output logic        tx,
    output logic        busy,
    output logic        overrun
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state_reg;
    logic [BAUD_W-1:0] baud_reg;
    logic [2:0]        bit_reg;
    logic [7:0]        shift_reg;
    logic              bit_end;

    // The current bit period finishes on this clock edge.
    assign bit_end = (baud_reg == BAUD_LAST);

    // Frame sequencer.
    // All outputs are registered and are updated together with the state.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg   <= INIT;
            baud_reg    <= '0;
            bit_reg     <= 3'd0;
            shift_reg   <= 8'h00;
            tx          <= 1'b1;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            ld_dsr_ext  <= 1'b0;
            dsr_ext_out <= 16'h0000;
        end else begin
            // The DSR strobe is a single-cycle pulse unless a state re-asserts it.
            ld_dsr_ext <= 1'b0;

            // A character offered outside IDLE is dropped.
            // The sticky flag records that it was lost.
            if (ld_ddr && (state_reg != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state_reg)
                // DSR comes out of reset as zero, so announce ready once.
                // The strobe rises on the first edge after release.
                // The next edge moves to IDLE, so that a DDR load cannot
                // produce a second strobe in the cycle directly after.
                INIT: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (!ld_dsr_ext) begin
                        ld_dsr_ext  <= 1'b1;
                        dsr_ext_out <= 16'h8000;
                    end else begin
                        state_reg <= IDLE;
                    end
                end

                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_reg <= '0;
                    if (ld_ddr) begin
                        shift_reg   <= mdr_out[7:0];
                        overrun     <= 1'b0;
                        state_reg   <= START;
                        tx          <= 1'b0;
                        busy        <= 1'b1;
                        ld_dsr_ext  <= 1'b1;
                        dsr_ext_out <= 16'h0000;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state_reg <= DATA;
                        baud_reg  <= '0;
                        bit_reg   <= 3'd0;
                        tx        <= shift_reg[0];
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end

                // Data bits go out LSB first.
                // Bits are indexed from shift_reg, so the latched character is never modified.
                DATA: begin
                    if (bit_end) begin
                        baud_reg <= '0;
                        if (bit_reg == 3'd7) begin
                            state_reg <= STOP;
                            tx        <= 1'b1;
                        end else begin
                            bit_reg <= bit_reg + 3'd1;
                            tx      <= shift_reg[bit_reg + 3'd1];
                        end
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        state_reg   <= DONE;
                        baud_reg    <= '0;
                        busy        <= 1'b0;
                        ld_dsr_ext  <= 1'b1;
                        dsr_ext_out <= 16'h8000;
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end

                DONE: begin
                    tx        <= 1'b1;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= INIT;
                end
            endcase
        end
    end

endmodule

// File: doc/display_uart_tx.md
Name: display_uart_tx

Overview:
- Display-side device behind the LC-3 memory-mapped display registers (DDR/DSR); the output counterpart to the keyboard input path.
- Accepts a character when the CPU loads DDR and serialises it as 8N1 UART on tx.
- Drives the DSR external-load path: clears DSR ready (bit 15) when a character is accepted and sets it again when the stop bit completes.
- Software polls DSR[15] before each write.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_  input  1  asynchronous, active-low reset
- ld_ddr  input  1  one-cycle pulse: CPU is loading DDR this cycle
- mdr_out  input  16  MDR contents; bits [7:0] are the character, [15:8] ignored
- ld_dsr_ext  output  1  one-cycle load strobe to the DSR external path
- dsr_ext_out  output  16  value loaded into DSR when ld_dsr_ext=1
- tx  output  1  UART serial out, idle high
- busy  output  1  high from character acceptance until the frame ends
- overrun  output  1  sticky: an ld_ddr arrived while not IDLE

Behaviour:
- Reset (async assert, sync use after deassert): state=INIT, tx=1, busy=0, overrun=0, ld_dsr_ext=0, dsr_ext_out=16'h0000, bit counter=0, baud counter=0.
- States: INIT, IDLE, START, DATA, STOP, DONE. All outputs are registered.
- INIT, for one cycle after reset release:
  - ld_dsr_ext=1, dsr_ext_out=16'h8000, announcing ready because DSR resets to 0.
  - Next state IDLE. An ld_ddr in INIT is ignored and sets overrun.
- IDLE: tx=1, busy=0, ld_dsr_ext=0. On ld_ddr sampled at edge N:
  - Latch mdr_out[7:0] into the shift register.
  - Clear overrun.
  - From cycle N+1: state=START, tx=0, busy=1, and for that cycle only ld_dsr_ext=1 with dsr_ext_out=16'h0000.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - Bit counter runs 0..7 and is cleared when DATA is entered.
  - After bit 7 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then DONE.
- DONE, one cycle: ld_dsr_ext=1, dsr_ext_out=16'h8000, tx=1, busy=0, then IDLE.
- Frame timing:
  - tx low edge at N+1; stop bit ends at N+1+10*CLKS_PER_BIT.
  - DONE occupies cycle N+1+10*CLKS_PER_BIT.
  - Earliest next accept is ld_ddr at edge N+2+10*CLKS_PER_BIT.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and is cleared on every bit boundary and on entry to START.
  - No drift across the frame.
- ld_ddr in any state other than IDLE (START/DATA/STOP/DONE/INIT):
  - Character is dropped and overrun is set.
  - The frame in progress and its shift register are unaffected.
- dsr_ext_out holds its last driven value when ld_dsr_ext=0. Consumers must use it only while ld_dsr_ext=1.
- In the status register, the external load (ld_dsr_ext) takes priority over a simultaneous CPU load.
- Reset asserted mid-frame:
  - tx returns to 1 immediately (async).
  - The frame is abandoned, with no DONE pulse.
  - After release, INIT re-announces ready.
- The block never produces ld_dsr_ext on two consecutive cycles.

Test Plan:
1. Reset release, CLKS_PER_BIT=4 -> first cycle ld_dsr_ext=1, dsr_ext_out=16'h8000; then tx=1, busy=0 held for 20 idle cycles.
2. ld_ddr with mdr_out=16'hFF41 ('A') at edge N -> at N+1 ld_dsr_ext=1/16'h0000.
   - tx sequence per 4-cycle bit: 0,1,0,0,0,0,0,1,0,1.
   - At N+41 ld_dsr_ext=1/16'h8000 and busy drops.
3. Back-to-back: 16'h0055 then 16'h00AA, the second issued at the earliest legal edge (N+42) -> two contiguous frames, overrun=0, tx bit patterns match LSB-first.
4. ld_ddr 16'h0033 during the DATA bit 3 of a frame for 16'h0041 -> frame for 0x41 completes intact, 0x33 never transmitted, overrun=1.
   - The next accepted ld_ddr clears overrun.
5. Assert reset_ mid-DATA -> tx=1 asynchronously and no DONE pulse.
   - After release, INIT pulse 16'h8000 appears; a subsequent 16'h0000 frame emits start bit + 8 zeros + stop.
6. CLKS_PER_BIT=868, send 16'h000D -> every bit lasts exactly 868 cycles; total from tx falling to ld_dsr_ext ready pulse = 8680 cycles.
